// File: rtl/rob_alloc.sv
// ROB entry allocator: hands out up to two consecutive ROB slots per cycle,
// tracks free entries from commit counts and recovers pointers on a flush.
module rob_alloc #(
   parameter int unsigned ROB_NUM        = 64,
   parameter int unsigned ROB_SEL        = 6,
   parameter int unsigned RESET_PTR      = 1,
   parameter int unsigned RECOVER_CYCLES = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               req1_i,
   input  logic               req2_i,
   input  logic               stall_i,
   input  logic [1:0]         comnum_i,
   input  logic [ROB_SEL-1:0] commit_ptr_i,
   input  logic               prmiss_i,
   output logic               dp1_o,
   output logic               dp2_o,
   output logic [ROB_SEL-1:0] dp1_addr_o,
   output logic [ROB_SEL-1:0] dp2_addr_o,
   output logic               alloc_stall_o,
   output logic [ROB_SEL:0]   freenum_o,
   output logic               full_o,
   output logic               empty_o,
   output logic               recovering_o,
   output logic               err_o
);

   localparam int unsigned FW = ROB_SEL + 1;
   localparam int unsigned SW = ROB_SEL + 2;
   localparam logic [FW-1:0] FREE_MAX = FW'(ROB_NUM);

   typedef enum logic {ST_NORMAL, ST_RECOVER} state_t;

   state_t             r_state;
   logic [ROB_SEL-1:0] r_ptr;
   logic [FW-1:0]      r_free;
   logic [2:0]         r_cnt;
   logic               r_err;

   logic [1:0]    w_comnum;
   logic [1:0]    w_need;
   logic [1:0]    w_alloc;
   logic          w_grant;
   logic [SW-1:0] w_sum;
   logic          w_ovf;
   logic          w_proto_err;

   // comnum of 3 is illegal and clamped to 2
   assign w_comnum = (comnum_i == 2'd3) ? 2'd2 : comnum_i;
   assign w_need   = {1'b0, req1_i} + {1'b0, req2_i};
   assign w_grant  = ~reset_i & req1_i & ~stall_i & ~prmiss_i
                   & (r_state == ST_NORMAL) & (r_free >= FW'(w_need));
   assign w_alloc  = w_grant ? w_need : 2'd0;

   // same-cycle commits only affect the next cycle's free count
   assign w_sum = SW'(r_free) - SW'(w_alloc) + SW'(w_comnum);
   assign w_ovf = (w_sum > SW'(ROB_NUM));

   assign w_proto_err = (req2_i & ~req1_i)
                      | (comnum_i == 2'd3)
                      | ((r_state == ST_RECOVER) & (comnum_i != 2'd0))
                      | (~prmiss_i & (r_state == ST_NORMAL) & w_ovf);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= ST_NORMAL;
         r_ptr   <= ROB_SEL'(RESET_PTR);
         r_free  <= FREE_MAX;
         r_cnt   <= 3'd0;
         r_err   <= 1'b0;
      end else begin
         if (w_proto_err) begin
            r_err <= 1'b1;
         end
         if (prmiss_i) begin
            // flush happens at commit of the branch, so the ROB is empty
            r_ptr   <= commit_ptr_i + ROB_SEL'(w_comnum);
            r_free  <= FREE_MAX;
            r_state <= ST_RECOVER;
            r_cnt   <= 3'(RECOVER_CYCLES - 1);
         end else if (r_state == ST_RECOVER) begin
            if (r_cnt == 3'd0) begin
               r_state <= ST_NORMAL;
            end else begin
               r_cnt <= r_cnt - 3'd1;
            end
         end else begin
            r_ptr  <= r_ptr + ROB_SEL'(w_alloc);
            r_free <= w_ovf ? FREE_MAX : w_sum[FW-1:0];
         end
      end
   end

   assign dp1_o         = w_grant;
   assign dp2_o         = w_grant & req2_i;
   assign dp1_addr_o    = r_ptr;
   assign dp2_addr_o    = r_ptr + ROB_SEL'(1);
   assign alloc_stall_o = req1_i & ~w_grant;
   assign freenum_o     = r_free;
   assign full_o        = (r_free == '0);
   assign empty_o       = (r_free == FREE_MAX);
   assign recovering_o  = (r_state == ST_RECOVER);
   assign err_o         = r_err;

endmodule

// File: tb/tb_rob_alloc.sv
// Self-checking bench for rob_alloc: vector table plus hand-built sequences,
// with expected outputs queued at drive time and checked mid-cycle.
module tb_rob_alloc;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       req1_i, req2_i, stall_i, prmiss_i;
   logic [1:0] comnum_i;
   logic [5:0] commit_ptr_i;
   logic       dp1_o, dp2_o, alloc_stall_o, full_o, empty_o, recovering_o, err_o;
   logic [5:0] dp1_addr_o, dp2_addr_o;
   logic [6:0] freenum_o;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       r1, r2, st;
      logic [1:0] cn;
      logic [5:0] cp;
      logic       pm;
      logic       e_dp1, e_dp2;
      logic [5:0] e_a1, e_a2;
      logic       e_ast;
      logic [6:0] e_free;
      logic       e_rec, e_err;
   } vec_t;

   vec_t exp_q[$];
   vec_t tbl[7];

   rob_alloc dut (
      .clk_i(clk_i), .reset_i(reset_i), .req1_i(req1_i), .req2_i(req2_i),
      .stall_i(stall_i), .comnum_i(comnum_i), .commit_ptr_i(commit_ptr_i),
      .prmiss_i(prmiss_i), .dp1_o(dp1_o), .dp2_o(dp2_o),
      .dp1_addr_o(dp1_addr_o), .dp2_addr_o(dp2_addr_o),
      .alloc_stall_o(alloc_stall_o), .freenum_o(freenum_o), .full_o(full_o),
      .empty_o(empty_o), .recovering_o(recovering_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic vec_t mk(input logic r1, r2, st, input logic [1:0] cn,
                               input logic [5:0] cp, input logic pm,
                               input logic d1, d2, input logic [5:0] a1, a2,
                               input logic ast, input logic [6:0] fr,
                               input logic rec, err);
      vec_t v;
      v.r1 = r1; v.r2 = r2; v.st = st; v.cn = cn; v.cp = cp; v.pm = pm;
      v.e_dp1 = d1; v.e_dp2 = d2; v.e_a1 = a1; v.e_a2 = a2; v.e_ast = ast;
      v.e_free = fr; v.e_rec = rec; v.e_err = err;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
      end
   endtask

   task automatic compare(input vec_t v);
      chk("dp1", int'(dp1_o), int'(v.e_dp1));
      chk("dp2", int'(dp2_o), int'(v.e_dp2));
      chk("dp1_addr", int'(dp1_addr_o), int'(v.e_a1));
      chk("dp2_addr", int'(dp2_addr_o), int'(v.e_a2));
      chk("alloc_stall", int'(alloc_stall_o), int'(v.e_ast));
      chk("freenum", int'(freenum_o), int'(v.e_free));
      chk("full", int'(full_o), (v.e_free == 7'd0) ? 1 : 0);
      chk("empty", int'(empty_o), (v.e_free == 7'd64) ? 1 : 0);
      chk("recovering", int'(recovering_o), int'(v.e_rec));
      chk("err", int'(err_o), int'(v.e_err));
   endtask

   // drive one cycle of stimulus; its expectation is checked at the negedge
   task automatic step(input vec_t v);
      req1_i = v.r1; req2_i = v.r2; stall_i = v.st;
      comnum_i = v.cn; commit_ptr_i = v.cp; prmiss_i = v.pm;
      exp_q.push_back(v);
      @(negedge clk_i);
      compare(exp_q.pop_front());
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      req1_i = 1'b0; req2_i = 1'b0; stall_i = 1'b0;
      comnum_i = 2'd0; commit_ptr_i = 6'd0; prmiss_i = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_i = 1'b1;
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
   endtask

   initial begin
      // r1 r2 st cn cp pm | dp1 dp2 a1 a2 ast free rec err
      tbl[0] = mk(1,1,0,2'd0,6'd0,0, 1,1,6'd1,6'd2,0,7'd64,0,0);
      tbl[1] = mk(0,0,0,2'd0,6'd0,0, 0,0,6'd3,6'd4,0,7'd62,0,0);
      tbl[2] = mk(1,0,0,2'd0,6'd0,0, 1,0,6'd3,6'd4,0,7'd62,0,0);
      tbl[3] = mk(1,0,1,2'd0,6'd0,0, 0,0,6'd4,6'd5,1,7'd61,0,0);
      tbl[4] = mk(0,0,0,2'd2,6'd0,0, 0,0,6'd4,6'd5,0,7'd61,0,0);
      tbl[5] = mk(1,1,0,2'd1,6'd0,0, 1,1,6'd4,6'd5,0,7'd63,0,0);
      tbl[6] = mk(0,0,0,2'd0,6'd0,0, 0,0,6'd6,6'd7,0,7'd62,0,0);

      do_reset();
      step(mk(0,0,0,2'd0,6'd0,0, 0,0,6'd1,6'd2,0,7'd64,0,0));
      for (int i = 0; i < 7; i++) step(tbl[i]);

      // wrap of the dispatch pointer, then fill to full
      do_reset();
      for (int k = 0; k < 31; k++)
         step(mk(1,1,0,2'd0,6'd0,0, 1,1,6'(1+2*k),6'(2+2*k),0,7'(64-2*k),0,0));
      step(mk(1,1,0,2'd0,6'd0,0, 1,1,6'd63,6'd0,0,7'd2,0,0));
      step(mk(1,0,0,2'd0,6'd0,0, 0,0,6'd1,6'd2,1,7'd0,0,0));
      step(mk(1,0,0,2'd1,6'd0,0, 0,0,6'd1,6'd2,1,7'd0,0,0));
      step(mk(1,1,0,2'd0,6'd0,0, 0,0,6'd1,6'd2,1,7'd1,0,0));
      step(mk(1,0,0,2'd0,6'd0,0, 1,0,6'd1,6'd2,0,7'd1,0,0));
      step(mk(0,0,0,2'd0,6'd0,0, 0,0,6'd2,6'd3,0,7'd0,0,0));

      // misprediction flush and recovery window
      do_reset();
      step(mk(1,0,0,2'd0,6'd0, 0, 1,0,6'd1,6'd2,0,7'd64,0,0));
      step(mk(1,1,0,2'd1,6'd10,1, 0,0,6'd2,6'd3,1,7'd63,0,0));
      step(mk(1,0,0,2'd0,6'd0, 0, 0,0,6'd11,6'd12,1,7'd64,1,0));
      step(mk(1,0,0,2'd0,6'd0, 0, 0,0,6'd11,6'd12,1,7'd64,1,0));
      step(mk(1,0,0,2'd0,6'd0, 0, 1,0,6'd11,6'd12,0,7'd64,0,0));
      step(mk(0,0,0,2'd0,6'd0, 0, 0,0,6'd12,6'd13,0,7'd63,0,0));

      // req2 without req1: no grant, error flag
      do_reset();
      step(mk(0,1,0,2'd0,6'd0,0, 0,0,6'd1,6'd2,0,7'd64,0,0));
      step(mk(0,0,0,2'd0,6'd0,0, 0,0,6'd1,6'd2,0,7'd64,0,1));

      // commit overflow: saturation and sticky error
      do_reset();
      step(mk(1,0,0,2'd0,6'd0,0, 1,0,6'd1,6'd2,0,7'd64,0,0));
      step(mk(0,0,0,2'd2,6'd0,0, 0,0,6'd2,6'd3,0,7'd63,0,0));
      step(mk(0,0,0,2'd0,6'd0,0, 0,0,6'd2,6'd3,0,7'd64,0,1));
      step(mk(0,0,0,2'd0,6'd0,0, 0,0,6'd2,6'd3,0,7'd64,0,1));

      // asynchronous reset away from a clock edge, with a pending request
      req1_i = 1'b1;
      #2;
      reset_i = 1'b1;
      #1;
      chk("async_reset_err", int'(err_o), 0);
      chk("async_reset_dp1", int'(dp1_o), 0);
      chk("async_reset_free", int'(freenum_o), 64);
      chk("async_reset_addr", int'(dp1_addr_o), 1);
      idle_inputs();
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
